maze_grid_memory: RTL and testbench

MAZE_GRID_MEMORY -- requirements
Module: maze_grid_memory

---
 rtl/maze_pkg.sv | 32 +++
 rtl/maze_grid_ram.sv | 31 +++
 rtl/maze_grid_memory.sv | 228 ++++++++++++++++++++++
 tb/tb_maze_grid_memory.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze grid memory.
//   - op-code constants (OP_READ, OP_WRITE, OP_PROBE; 2'b11 is reserved)
//   - controller state enum
//   - bit positions of the probe wall mask {N,E,S,W}
//   - cell_addr(): row-major cell address helper
// Optional feature macro: MAZE_GRID_PROBE_EN (adds the PROBE state).
package maze_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_PROBE = 2'b10;

    localparam int unsigned NBR_N = 3;
    localparam int unsigned NBR_E = 2;
    localparam int unsigned NBR_S = 1;
    localparam int unsigned NBR_W = 0;

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StIdle  = 2'd1,
`ifdef MAZE_GRID_PROBE_EN
        StProbe = 2'd2,
`endif
        StResp  = 2'd3
    } maze_state_e;

    function automatic int unsigned cell_addr(input int unsigned row, input int unsigned col,
                                              input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/maze_grid_ram.sv
// Single-port synchronous RAM holding the maze map.
//   clk_i   : clock
//   we_i    : write enable (write-first is not required; read returns old data)
//   addr_i  : cell address, row-major (x*COLS+y)
//   wdata_i : write data
//   rdata_o : registered read data, valid the cycle after the address is presented
module maze_grid_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = 8,
    parameter int unsigned CELL_W = 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [CELL_W-1:0] wdata_i,
    output logic [CELL_W-1:0] rdata_o
);

    logic [CELL_W-1:0] mem [DEPTH];
    logic [CELL_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/maze_grid_memory.sv
// Maze grid memory: ROWS x COLS map of CELL_W-bit cells (non-zero = wall).
// After reset or init the whole map is swept to zero, one cell per cycle.
//   clk, rst (async, active-high), init (sync re-clear request)
//   req/op/x/y/din : request, accepted when ready=1
//   ready, busy    : controller status
//   valid          : one-cycle response pulse qualifying dout, nbr, err
// Optional feature macro: MAZE_GRID_PROBE_EN enables op=10 (probe the four
// neighbours, wall mask on nbr as {N,E,S,W}); otherwise op=10 answers err=1.
module maze_grid_memory
    import maze_pkg::*;
#(
    parameter int unsigned COLS   = 16,
    parameter int unsigned ROWS   = 16,
    parameter int unsigned CELL_W = 1,
    localparam int unsigned XW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned YW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [CELL_W-1:0] din,
    output logic              ready,
    output logic              valid,
    output logic [CELL_W-1:0] dout,
    output logic [3:0]        nbr,
    output logic              err,
    output logic              busy
);

    localparam int unsigned DEPTH = ROWS * COLS;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    maze_state_e       state_q, state_d;
    logic [AW-1:0]     sweep_q, sweep_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;

    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [CELL_W-1:0] ram_wdata;
    logic [CELL_W-1:0] ram_rdata;

    logic              in_range;
    logic [AW-1:0]     addr_in;

    assign in_range = (32'(x) < ROWS) && (32'(y) < COLS);
    assign addr_in  = AW'(cell_addr(32'(x), 32'(y), COLS));

`ifdef MAZE_GRID_PROBE_EN
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d;
    logic [3:0]    oob_q, oob_d;
    logic [2:0]    nbr_q, nbr_d;    // captured {N,E,S}; W arrives from the RAM in StResp
    logic [1:0]    pidx_q, pidx_d;
    logic          probe_q, probe_d;

    // Neighbour k (0=N, 1=E, 2=S, 3=W) address; off-grid neighbours map to 0
    // since their data is replaced by the out-of-bounds flag anyway.
    function automatic logic [AW-1:0] nbr_addr(input logic [XW-1:0] row,
                                               input logic [YW-1:0] col,
                                               input logic [1:0]    k);
        int unsigned r;
        int unsigned c;
        r = 32'(row);
        c = 32'(col);
        case (k)
            2'd0:    r = r - 1;
            2'd1:    c = c + 1;
            2'd2:    r = r + 1;
            default: c = c - 1;
        endcase
        if (r >= ROWS || c >= COLS) begin
            return '0;
        end
        return AW'(cell_addr(r, c, COLS));
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            sweep_q <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
`ifdef MAZE_GRID_PROBE_EN
            px_q    <= '0;
            py_q    <= '0;
            oob_q   <= '0;
            nbr_q   <= '0;
            pidx_q  <= '0;
            probe_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
`ifdef MAZE_GRID_PROBE_EN
            px_q    <= px_d;
            py_q    <= py_d;
            oob_q   <= oob_d;
            nbr_q   <= nbr_d;
            pidx_q  <= pidx_d;
            probe_q <= probe_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        err_d     = err_q;
        rd_d      = rd_q;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
`ifdef MAZE_GRID_PROBE_EN
        px_d      = px_q;
        py_d      = py_q;
        oob_d     = oob_q;
        nbr_d     = nbr_q;
        pidx_d    = pidx_q;
        probe_d   = probe_q;
`endif
        case (state_q)
            StClear: begin
                ram_we   = 1'b1;
                ram_addr = sweep_q;
                if (sweep_q == AW'(DEPTH - 1)) begin
                    sweep_d = '0;
                    state_d = StIdle;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            StIdle: begin
                if (req) begin
                    err_d   = 1'b0;
                    rd_d    = 1'b0;
                    state_d = StResp;
`ifdef MAZE_GRID_PROBE_EN
                    nbr_d   = '0;
                    probe_d = 1'b0;
`endif
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        case (op)
                            OP_READ: begin
                                ram_addr = addr_in;
                                rd_d     = 1'b1;
                            end
                            OP_WRITE: begin
                                ram_we    = 1'b1;
                                ram_addr  = addr_in;
                                ram_wdata = din;
                            end
`ifdef MAZE_GRID_PROBE_EN
                            OP_PROBE: begin
                                px_d         = x;
                                py_d         = y;
                                pidx_d       = 2'd0;
                                oob_d[NBR_N] = (x == '0);
                                oob_d[NBR_E] = (32'(y) == COLS - 1);
                                oob_d[NBR_S] = (32'(x) == ROWS - 1);
                                oob_d[NBR_W] = (y == '0);
                                // N is read on the accepting edge to reach the
                                // four-cycle latency with a registered RAM.
                                ram_addr     = nbr_addr(x, y, 2'd0);
                                state_d      = StProbe;
                            end
`endif
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            end
`ifdef MAZE_GRID_PROBE_EN
            StProbe: begin
                // Capture neighbour pidx, issue read of neighbour pidx+1.
                nbr_d[2'd2 - pidx_q] = oob_q[2'd3 - pidx_q] | (|ram_rdata);
                ram_addr             = nbr_addr(px_q, py_q, pidx_q + 2'd1);
                pidx_d               = pidx_q + 2'd1;
                if (pidx_q == 2'd2) begin
                    probe_d = 1'b1;
                    state_d = StResp;
                end
            end
`endif
            StResp:  state_d = StIdle;
            default: state_d = StClear;
        endcase

        if (init) begin
            state_d = StClear;
            sweep_d = '0;
            ram_we  = 1'b0;
        end
    end

    maze_grid_ram #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .CELL_W (CELL_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign ready = (state_q == StIdle) && !init;
    assign busy  = (state_q == StClear);
    assign valid = (state_q == StResp) && !init;
    assign dout  = (valid && rd_q) ? ram_rdata : '0;
    assign err   = valid && err_q;
`ifdef MAZE_GRID_PROBE_EN
    assign nbr   = (valid && probe_q) ? {nbr_q, oob_q[NBR_W] | (|ram_rdata)} : 4'b0;
`else
    assign nbr   = 4'b0;
`endif

endmodule

// File: tb/tb_maze_grid_memory.sv
// Directed bench for maze_grid_memory: a default 16x16 instance and a
// 10-row instance for out-of-range checks. Inputs change 1 time unit after
// the rising edge; outputs are sampled at the same point.
module tb_maze_grid_memory;
    import maze_pkg::*;

    logic       clk;
    logic       rst;

    logic       a_init, a_req;
    logic [1:0] a_op;
    logic [3:0] a_x, a_y;
    logic [0:0] a_din, a_dout;
    logic       a_ready, a_valid, a_err, a_busy;
    logic [3:0] a_nbr;

    logic       b_init, b_req;
    logic [1:0] b_op;
    logic [3:0] b_x, b_y;
    logic [0:0] b_din, b_dout;
    logic       b_ready, b_valid, b_err, b_busy;
    logic [3:0] b_nbr;

    int n_chk;
    int n_err;

    maze_grid_memory u_dut (
        .clk   (clk),   .rst   (rst),     .init (a_init), .req (a_req),
        .op    (a_op),  .x     (a_x),     .y    (a_y),    .din (a_din),
        .ready (a_ready), .valid (a_valid), .dout (a_dout), .nbr (a_nbr),
        .err   (a_err), .busy  (a_busy)
    );

    maze_grid_memory #(.ROWS(10)) u_dut10 (
        .clk   (clk),   .rst   (rst),     .init (b_init), .req (b_req),
        .op    (b_op),  .x     (b_x),     .y    (b_y),    .din (b_din),
        .ready (b_ready), .valid (b_valid), .dout (b_dout), .nbr (b_nbr),
        .err   (b_err), .busy  (b_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit sel, input logic [1:0] o, input logic [3:0] xi,
                         input logic [3:0] yi, input logic d);
        if (sel) begin
            b_req = 1'b1; b_op = o; b_x = xi; b_y = yi; b_din = d;
        end else begin
            a_req = 1'b1; a_op = o; a_x = xi; a_y = yi; a_din = d;
        end
        step();
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    // Checks the response pulse present now, then lets the FSM return to idle.
    task automatic expect_resp(input bit sel, input string tag, input logic d, input logic e);
        check_eq({tag, " valid"}, sel ? b_valid : a_valid, 1);
        check_eq({tag, " dout"},  sel ? b_dout  : a_dout,  d);
        check_eq({tag, " err"},   sel ? b_err   : a_err,   e);
        check_eq({tag, " nbr"},   sel ? b_nbr   : a_nbr,   0);
        check_eq({tag, " ready"}, sel ? b_ready : a_ready, 0);
        step();
        check_eq({tag, " valid_drop"}, sel ? b_valid : a_valid, 0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (a_busy && n < 2000) begin
            n++;
            step();
        end
    endtask

`ifdef MAZE_GRID_PROBE_EN
    task automatic probe(input logic [3:0] xi, input logic [3:0] yi,
                         input logic [3:0] exp_nbr, input string tag);
        int n;
        issue(1'b0, OP_PROBE, xi, yi, 1'b0);
        n = 1;
        while (!a_valid && n < 20) begin
            n++;
            step();
        end
        check_eq({tag, " latency"}, n, 4);
        check_eq({tag, " nbr"}, a_nbr, exp_nbr);
        check_eq({tag, " err"}, a_err, 0);
        check_eq({tag, " dout"}, a_dout, 0);
        step();
        check_eq({tag, " valid_drop"}, a_valid, 0);
    endtask
`endif

    initial begin
        int n;
        clk = 1'b0;
        rst = 1'b1;
        a_init = 0; a_req = 0; a_op = 0; a_x = 0; a_y = 0; a_din = 0;
        b_init = 0; b_req = 0; b_op = 0; b_x = 0; b_y = 0; b_din = 0;
        n_chk = 0;
        n_err = 0;

        // Asynchronous reset: outputs settle before any clock edge.
        #3;
        check_eq("rst ready", a_ready, 0);
        check_eq("rst busy",  a_busy,  1);
        check_eq("rst valid", a_valid, 0);
        check_eq("rst dout",  a_dout,  0);
        check_eq("rst err",   a_err,   0);
        check_eq("rst nbr",   a_nbr,   0);
        step();
        step();
        rst = 1'b0;

        count_busy(n);
        check_eq("clear cycles", n, 256);
        check_eq("ready after clear", a_ready, 1);
        check_eq("ready10 after clear", b_ready, 1);

        issue(1'b0, OP_READ, 4'd15, 4'd15, 1'b0);
        expect_resp(1'b0, "rd 15,15", 1'b0, 1'b0);
        issue(1'b0, OP_WRITE, 4'd3, 4'd4, 1'b1);
        expect_resp(1'b0, "wr 3,4", 1'b0, 1'b0);
        issue(1'b0, OP_READ, 4'd3, 4'd4, 1'b0);
        expect_resp(1'b0, "rd 3,4", 1'b1, 1'b0);
        issue(1'b0, OP_READ, 4'd3, 4'd5, 1'b0);
        expect_resp(1'b0, "rd 3,5", 1'b0, 1'b0);
        issue(1'b0, 2'b11, 4'd1, 4'd1, 1'b1);
        expect_resp(1'b0, "op11", 1'b0, 1'b1);

        // 10-row instance: x=12 and x=10 are off-grid, x=9 is the last row.
        issue(1'b1, OP_WRITE, 4'd12, 4'd2, 1'b1);
        expect_resp(1'b1, "oor wr 12,2", 1'b0, 1'b1);
        issue(1'b1, OP_READ, 4'd2, 4'd2, 1'b0);
        expect_resp(1'b1, "rd10 2,2", 1'b0, 1'b0);
        issue(1'b1, OP_READ, 4'd10, 4'd0, 1'b0);
        expect_resp(1'b1, "oor rd 10,0", 1'b0, 1'b1);
        issue(1'b1, OP_WRITE, 4'd9, 4'd15, 1'b1);
        expect_resp(1'b1, "wr10 9,15", 1'b0, 1'b0);
        issue(1'b1, OP_READ, 4'd9, 4'd15, 1'b0);
        expect_resp(1'b1, "rd10 9,15", 1'b1, 1'b0);

`ifdef MAZE_GRID_PROBE_EN
        issue(1'b0, OP_WRITE, 4'd1, 4'd0, 1'b1);
        expect_resp(1'b0, "wr 1,0", 1'b0, 1'b0);
        probe(4'd0, 4'd0, 4'b1011, "probe 0,0");
        issue(1'b0, OP_WRITE, 4'd4, 4'd5, 1'b1);
        expect_resp(1'b0, "wr 4,5", 1'b0, 1'b0);
        issue(1'b0, OP_WRITE, 4'd5, 4'd6, 1'b1);
        expect_resp(1'b0, "wr 5,6", 1'b0, 1'b0);
        probe(4'd5, 4'd5, 4'b1100, "probe 5,5");
        probe(4'd15, 4'd15, 4'b0110, "probe 15,15");

        // init on the second probe cycle aborts the probe.
        issue(1'b0, OP_PROBE, 4'd3, 4'd3, 1'b0);
        step();
        a_init = 1'b1;
        #1;
        check_eq("init probe valid", a_valid, 0);
        check_eq("init probe ready", a_ready, 0);
        step();
        a_init = 1'b0;
        begin
            int seen;
            seen = 0;
            n = 0;
            while (a_busy && n < 2000) begin
                if (a_valid) seen++;
                n++;
                step();
            end
            check_eq("init probe no valid", seen, 0);
        end
        check_eq("reclear cycles", n, 256);
        issue(1'b0, OP_READ, 4'd3, 4'd4, 1'b0);
        expect_resp(1'b0, "rd 3,4 after init", 1'b0, 1'b0);
`else
        issue(1'b0, OP_PROBE, 4'd5, 4'd5, 1'b0);
        expect_resp(1'b0, "probe disabled", 1'b0, 1'b1);
`endif

        // init wins over a simultaneous write request.
        issue(1'b0, OP_WRITE, 4'd7, 4'd7, 1'b1);
        expect_resp(1'b0, "wr 7,7", 1'b0, 1'b0);
        issue(1'b0, OP_WRITE, 4'd3, 4'd4, 1'b1);
        expect_resp(1'b0, "wr 3,4 again", 1'b0, 1'b0);
        a_init = 1'b1;
        a_req  = 1'b1; a_op = OP_WRITE; a_x = 4'd8; a_y = 4'd8; a_din = 1'b1;
        #1;
        check_eq("init ready", a_ready, 0);
        step();
        a_init = 1'b0;
        a_req  = 1'b0;
        check_eq("init valid", a_valid, 0);
        count_busy(n);
        check_eq("init clear cycles", n, 256);
        issue(1'b0, OP_READ, 4'd7, 4'd7, 1'b0);
        expect_resp(1'b0, "rd 7,7 after init", 1'b0, 1'b0);
        issue(1'b0, OP_READ, 4'd8, 4'd8, 1'b0);
        expect_resp(1'b0, "rd 8,8 after init", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
